dmem_responder: RTL and testbench
=================================

Name: dmem_responder

Overview:
- Word-organised data memory that acts as the responder side of the CPU memory-stage load/store interface.
- Accepts one request at a time through a valid/ready handshake. Stores commit on the accept edge. Read data returns after a parameterised latency.
- Drives a stall indication back to the pipeline while a request is pending and not accepted.
- Replaces the single-cycle data memory wherever a multi-cycle memory model is required.

Parameters:
- ADDR_W, 8: word-index width; depth = 2**ADDR_W words.
- DATA_W, 32: data word width.
- LATENCY, 2: cycles from the read accept edge to resp_valid high. Legal range is 1..15; elaboration fails outside it.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req_valid  input  1  request present.
- req_wr  input  1  1 = store, 0 = load.
- req_adr  input  32  byte address; word index = req_adr[ADDR_W+1:2].
- req_wdata  input  DATA_W  store data.
- req_ready  output  1  responder can accept this cycle.
- resp_valid  output  1  one-cycle response pulse.
- resp_rdata  output  DATA_W  load data; valid only while resp_valid=1.
- resp_err  output  1  misaligned-access flag; valid only while resp_valid=1.
- stall  output  1  req_valid & ~req_ready; combinational.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, counter=0, resp_valid=0, resp_rdata=0, resp_err=0.
  - req_ready=1 once state is IDLE.
  - Memory array is not reset; contents persist across reset.
- States: IDLE, WAIT, RESP.
- req_ready=1 in IDLE and RESP; 0 in WAIT.
- Accept = req_valid & req_ready at a rising edge. Only one transaction is in flight.
- Misaligned accept (req_adr[1:0]!=0):
  - No array write.
  - Next state RESP with resp_err=1, resp_rdata=0, after 1 cycle regardless of LATENCY.
- Aligned store accept:
  - array[idx] <= req_wdata on the accept edge.
  - Next state RESP; resp_valid=1 the following cycle with resp_rdata=0, resp_err=0. Store latency is always 1.
- Aligned load accept:
  - Word index is latched and counter loaded with LATENCY-1.
  - If LATENCY=1, go directly to RESP.
  - Otherwise go to WAIT. WAIT decrements the counter each cycle and moves to RESP when the counter reaches 1 → it decrements.
  - In RESP, resp_rdata = array[latched idx] sampled on the edge entering RESP; resp_err=0.
  - resp_valid rises exactly LATENCY cycles after the accept edge.
- RESP lasts one cycle:
  - With an accept in the same cycle, the next state follows the rules above (back-to-back).
  - Otherwise return to IDLE, with resp_valid=0.
- Throughput:
  - LATENCY=1 and stores/misaligned: one transaction per cycle.
  - Loads with LATENCY=N: one transaction per N cycles.
- Address upper bits req_adr[31:ADDR_W+2] are ignored; addresses alias modulo depth, with no error.
- Read-after-write: a load accepted any cycle after a store to the same index returns the stored data.
- req_wr, req_adr, and req_wdata are sampled only on the accept edge. Changes while req_ready=0 are ignored. The requester must hold req_valid until accepted.
- Reset mid-operation:
  - An in-flight load is dropped and no resp_valid is produced.
  - A store already accepted stays committed.
- resp_rdata and resp_err hold 0 whenever resp_valid=0.

Test Plan:
1. Reset then idle: rst_n low 3 cycles → resp_valid=0, resp_rdata=0, req_ready=1, stall=0 after release.
2. Store/load, LATENCY=2:
   - Store adr=0x10, data=0xDEADBEEF → resp_valid pulse 1 cycle later with rdata=0.
   - Load adr=0x10 → req_ready=0 and stall=1 for 1 cycle if req_valid is held; resp_valid exactly 2 cycles after accept with rdata=0xDEADBEEF.
3. Back-to-back at LATENCY=1:
   - Stores to 0x0, 0x4, 0x8 (data 1, 2, 3), then loads of the same addresses on consecutive cycles → resp_valid high 6 consecutive cycles.
   - Load rdata is 1, 2, 3 in order.
4. Misaligned and aliasing:
   - Store to adr=0x13 → resp_err=1, rdata=0, and the word at idx 4 is unchanged (a later load of 0x10 returns its old value).
   - Store 0x55 to adr=0x400 (ADDR_W=8), then load adr=0x0 → returns 0x55.
5. Reset mid-load, LATENCY=4:
   - Assert rst_n=0 two cycles after a load accept → no resp_valid ever appears for that load; state returns to IDLE with req_ready=1.
   - A store committed before the reset is still readable afterwards.
6. Stall hold: load issued while in WAIT with changing req_adr → only the value present on the accept edge is used; stall=1 for every WAIT cycle with req_valid=1.

Source files
------------

// File: rtl/dmem_responder.sv
// Word-organised data memory answering memory-stage load/store requests
// over a valid/ready handshake with configurable load latency.
module dmem_responder #(
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 32,
    parameter int LATENCY = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    input  logic              req_wr,
    input  logic [31:0]       req_adr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              req_ready,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_err,
    output logic              stall
);

    localparam int DEPTH = 2 ** ADDR_W;

    if (LATENCY < 1 || LATENCY > 15) begin : g_bad_latency
        $error("dmem_responder: LATENCY must be within 1..15");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_e;

    state_e            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              err_q, err_d;

    logic [DATA_W-1:0] mem [DEPTH];

    logic              accept;
    logic              misaligned;
    logic              mem_we;
    logic [ADDR_W-1:0] req_idx;
    logic              unused_adr;

    assign req_idx    = req_adr[ADDR_W+1:2];
    assign misaligned = (req_adr[1:0] != 2'b00);
    assign req_ready  = (state_q != S_WAIT);
    assign accept     = req_valid & req_ready;
    assign mem_we     = accept & req_wr & ~misaligned;
    assign stall      = req_valid & ~req_ready;
    assign unused_adr = ^req_adr[31:ADDR_W+2];

    assign resp_valid = (state_q == S_RESP);
    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;

    // Array is deliberately not reset so contents survive rst_n.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[req_idx] <= req_wdata;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        rdata_d = '0;
        err_d   = 1'b0;
        unique case (state_q)
            S_IDLE, S_RESP: begin
                if (!accept) begin
                    state_d = S_IDLE;
                end else if (misaligned) begin
                    state_d = S_RESP;
                    err_d   = 1'b1;
                end else if (req_wr) begin
                    state_d = S_RESP;
                end else if (LATENCY == 1) begin
                    state_d = S_RESP;
                    rdata_d = mem[req_idx];
                end else begin
                    state_d = S_WAIT;
                    cnt_d   = 4'(LATENCY - 1);
                    idx_d   = req_idx;
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d = S_RESP;
                    rdata_d = mem[idx_q];
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder at LATENCY 1, 2 and 4.
module tb_dmem_responder;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        vld [3];
    logic        wr  [3];
    logic [31:0] adr [3];
    logic [31:0] wd  [3];
    logic        rdy [3];
    logic        rv  [3];
    logic [31:0] rd  [3];
    logic        er  [3];
    logic        st  [3];

    int cyc = 0;
    int errors = 0;
    int checks = 0;
    int last_wait = 0;

    typedef struct {
        int          k;
        int          due;
        logic [31:0] rd;
        logic        err;
    } exp_t;

    exp_t sbq[$];
    exp_t mon_e;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int L = (g == 0) ? 1 : (g == 1) ? 2 : 4;
        dmem_responder #(
            .ADDR_W (8),
            .DATA_W (32),
            .LATENCY(L)
        ) u_dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .req_valid (vld[g]),
            .req_wr    (wr[g]),
            .req_adr   (adr[g]),
            .req_wdata (wd[g]),
            .req_ready (rdy[g]),
            .resp_valid(rv[g]),
            .resp_rdata(rd[g]),
            .resp_err  (er[g]),
            .stall     (st[g])
        );
    end

    function automatic int lat_of(input int k);
        return (k == 0) ? 1 : (k == 1) ? 2 : 4;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rst_n) begin
            for (int k = 0; k < 3; k++) begin
                checks++;
                if (rv[k]) begin
                    if (sbq.size() == 0) begin
                        errors++;
                        $display("FAIL resp_unexpected dut%0d rdata=%h err=%b",
                                 k, rd[k], er[k]);
                    end else begin
                        mon_e = sbq.pop_front();
                        if (mon_e.k !== k || mon_e.due !== cyc ||
                            rd[k] !== mon_e.rd || er[k] !== mon_e.err) begin
                            errors++;
                            $display("FAIL resp dut%0d cyc=%0d rdata=%h err=%b want dut%0d cyc=%0d rdata=%h err=%b",
                                     k, cyc, rd[k], er[k],
                                     mon_e.k, mon_e.due, mon_e.rd, mon_e.err);
                        end
                    end
                end else if (rd[k] !== 32'h0 || er[k] !== 1'b0) begin
                    errors++;
                    $display("FAIL resp_idle_zero dut%0d rdata=%h err=%b want 0/0",
                             k, rd[k], er[k]);
                end
            end
            if (sbq.size() > 0 && cyc > sbq[0].due) begin
                checks++;
                errors++;
                $display("FAIL resp_missing dut%0d no response by cyc=%0d",
                         sbq[0].k, sbq[0].due);
                void'(sbq.pop_front());
            end
        end
    end

    task automatic issue(input int k, input logic w, input logic [31:0] a,
                         input logic [31:0] d, input logic [31:0] xrd,
                         input logic xerr);
        int   n;
        logic acc;
        exp_t e;
        vld[k] = 1'b1;
        wr[k]  = w;
        adr[k] = a;
        wd[k]  = d;
        last_wait = 0;
        acc = 1'b0;
        n = 0;
        while (!acc && n < 50) begin
            @(negedge clk);
            acc = rdy[k];
            if (!acc) begin
                last_wait++;
                checks++;
                if (st[k] !== 1'b1) begin
                    errors++;
                    $display("FAIL stall dut%0d got %b want 1", k, st[k]);
                end
            end
            @(posedge clk);
            n++;
        end
        #1;
        if (!acc) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout dut%0d adr=%h", k, a);
        end else begin
            e.k   = k;
            e.due = cyc + ((w || a[1:0] != 2'b00) ? 0 : lat_of(k) - 1);
            e.rd  = xrd;
            e.err = xerr;
            sbq.push_back(e);
        end
        vld[k] = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sbq.size() > 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (rv[k] !== 1'b0 || rd[k] !== 32'h0 ||
                rdy[k] !== 1'b1 || st[k] !== 1'b0) begin
                errors++;
                $display("FAIL reset_state dut%0d rv=%b rd=%h rdy=%b stall=%b want 0/0/1/0",
                         k, rv[k], rd[k], rdy[k], st[k]);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_store_load();
        issue(1, 1'b1, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0);
        issue(1, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0);
        issue(1, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0);
        checks++;
        if (last_wait !== 1) begin
            errors++;
            $display("FAIL lat2_stall_cycles got %0d want 1", last_wait);
        end
        drain();
    endtask

    task automatic test_back_to_back();
        int first_e;
        int waits;
        waits = 0;
        issue(0, 1'b1, 32'h0, 32'd1, 32'h0, 1'b0);
        first_e = cyc;
        issue(0, 1'b1, 32'h4, 32'd2, 32'h0, 1'b0);
        waits += last_wait;
        issue(0, 1'b1, 32'h8, 32'd3, 32'h0, 1'b0);
        waits += last_wait;
        issue(0, 1'b0, 32'h0, 32'h0, 32'd1, 1'b0);
        waits += last_wait;
        issue(0, 1'b0, 32'h4, 32'h0, 32'd2, 1'b0);
        waits += last_wait;
        issue(0, 1'b0, 32'h8, 32'h0, 32'd3, 1'b0);
        waits += last_wait;
        checks++;
        if (cyc - first_e !== 5 || waits !== 0) begin
            errors++;
            $display("FAIL b2b_throughput span=%0d waits=%0d want 5/0",
                     cyc - first_e, waits);
        end
        drain();
    endtask

    task automatic test_misalign_alias();
        issue(1, 1'b1, 32'h13, 32'hFFFFFFFF, 32'h0, 1'b1);
        issue(1, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0);
        issue(1, 1'b0, 32'h12, 32'h0, 32'h0, 1'b1);
        issue(1, 1'b1, 32'h400, 32'h55, 32'h0, 1'b0);
        issue(1, 1'b0, 32'h0, 32'h0, 32'h55, 1'b0);
        issue(1, 1'b0, 32'hFFFFFC10, 32'h0, 32'hDEADBEEF, 1'b0);
        drain();
    endtask

    task automatic test_reset_mid_load();
        issue(2, 1'b1, 32'h20, 32'hA5A5A5A5, 32'h0, 1'b0);
        issue(2, 1'b0, 32'h20, 32'h0, 32'hA5A5A5A5, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        sbq.delete();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (rdy[2] !== 1'b1 || rv[2] !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_load rdy=%b rv=%b want 1/0", rdy[2], rv[2]);
        end
        repeat (6) @(posedge clk);
        #1;
        issue(2, 1'b0, 32'h20, 32'h0, 32'hA5A5A5A5, 1'b0);
        drain();
    endtask

    task automatic test_stall_hold();
        int   n;
        int   waited;
        logic acc;
        exp_t e;
        issue(2, 1'b1, 32'h40, 32'h11111111, 32'h0, 1'b0);
        issue(2, 1'b1, 32'h44, 32'h22222222, 32'h0, 1'b0);
        issue(2, 1'b1, 32'h48, 32'h33333333, 32'h0, 1'b0);
        issue(2, 1'b0, 32'h40, 32'h0, 32'h11111111, 1'b0);
        vld[2] = 1'b1;
        wr[2]  = 1'b0;
        adr[2] = 32'h44;
        waited = 0;
        acc = 1'b0;
        n = 0;
        while (!acc && n < 50) begin
            @(negedge clk);
            if (!rdy[2]) begin
                waited++;
                checks++;
                if (st[2] !== 1'b1) begin
                    errors++;
                    $display("FAIL stall_hold_stall got %b want 1", st[2]);
                end
                wr[2]  = 1'b1;
                adr[2] = 32'h48;
                wd[2]  = 32'hBAD0BAD0 + 32'(waited);
            end else begin
                wr[2]  = 1'b0;
                adr[2] = 32'h44;
                acc = 1'b1;
            end
            @(posedge clk);
            n++;
        end
        #1;
        vld[2] = 1'b0;
        e.k   = 2;
        e.due = cyc + 3;
        e.rd  = 32'h22222222;
        e.err = 1'b0;
        sbq.push_back(e);
        checks++;
        if (waited !== 3) begin
            errors++;
            $display("FAIL stall_hold_cycles got %0d want 3", waited);
        end
        issue(2, 1'b0, 32'h48, 32'h0, 32'h33333333, 1'b0);
        drain();
    endtask

    initial begin
        for (int k = 0; k < 3; k++) begin
            vld[k] = 1'b0;
            wr[k]  = 1'b0;
            adr[k] = 32'h0;
            wd[k]  = 32'h0;
        end
        test_reset();
        test_store_load();
        test_back_to_back();
        test_misalign_alias();
        test_reset_mid_load();
        test_stall_hold();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule
